tea_decrypt_serial: RTL and testbench
=====================================

Name: tea_decrypt_serial

Overview:
- Bit-serial receiving end for TEA ciphertext. Deserializes a 64-bit ciphertext block (v0 then v1, MSB-first) from a 1-bit stream and decrypts it iteratively, one full round per clock, with a parallel 128-bit key.
- Presents the 64-bit plaintext on a valid/ready output handshake.
- Sits beside the existing tea encrypt/decrypt cores as the consumer of serialized ciphertext.

Parameters:
- ROUNDS, 32: number of TEA cycles; legal range 1..63.
- DELTA, 32'h9E3779B9: key schedule constant.
- SUM_INIT, (DELTA*ROUNDS) mod 2^32, i.e. 32'hC6EF3720 for 32 rounds: initial sum for decryption; derived, not overridden.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- key  in  128  k0=key[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
- sin_valid  in  1  serial bit present this cycle.
- sin_bit  in  1  serial ciphertext bit.
- sin_ready  out  1  receiver accepts a bit this cycle.
- pt  out  64  plaintext {v0,v1}; valid only while out_valid=1.
- out_valid  out  1  plaintext available.
- out_ready  in  1  consumer accepts plaintext.
- done  out  1  one-cycle pulse on the edge out_valid rises.
- blk_count  out  16  completed-block counter (see Optional Feature).

Behaviour:
- Reset values: state=IDLE, sin_ready=1, out_valid=0, done=0, pt=0, bit counter=0, sum=SUM_INIT, blk_count=0.
- Reset mid-operation aborts immediately. Any partial block or partial decryption is discarded with no output.
- FSM states: IDLE, RECV, ROUND, OUT.
- IDLE:
  - sin_ready=1.
  - A bit transfers when sin_valid&sin_ready.
  - The first transfer shifts the bit in, latches key into an internal register, sets bit count to 1 and moves to RECV.
- RECV:
  - sin_ready=1.
  - Each transfer shifts left into a 64-bit register (first bit ends at v0[31]) and increments the count.
  - The transfer that makes count=64 moves to ROUND and loads sum=SUM_INIT and round counter=0.
  - Gaps (sin_valid=0) are allowed indefinitely.
- ROUND:
  - sin_ready=0.
  - Each cycle, using the latched key and all 32-bit arithmetic mod 2^32, with the logical shift >>5:
    - v1' = v1 - (((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3))
    - v0' = v0 - (((v1'<<4)+k0) ^ (v1'+sum) ^ ((v1'>>5)+k1))
    - sum' = sum - DELTA
  - After ROUNDS round edges, move to OUT: out_valid=1, pt={v0,v1}, done pulses for one cycle.
  - Latency: out_valid is high ROUNDS edges after the edge that sampled bit 64.
- OUT:
  - sin_ready=0, out_valid held, pt stable.
  - On out_valid&out_ready: return to IDLE, out_valid=0 next edge, bit count cleared.
  - sin_ready is 1 in the cycle after the handshake. No bit is accepted in the handshake cycle.
- Input handling:
  - sin_valid outside IDLE/RECV is ignored and no bit is consumed.
  - key changes after the first bit are ignored until the next block.
  - out_ready while out_valid=0 has no effect.
- done is never high while reset is asserted. done=0 in every cycle other than the OUT-entry edge.

Optional Feature:
- Macro: TEA_BLOCK_COUNT_EN.
- Defined: blk_count increments by 1 on each out handshake and wraps 16'hFFFF->0. It is cleared only by reset.
- Undefined: blk_count is tied to 0 and no counter register exists. The port stays present so the interface is stable.

Test Plan:
- Zero key, stream 64 bits of 0x41EA3A0A_94BAA940 with sin_valid held high, out_ready=1 -> out_valid exactly 32 edges after bit 64, pt=64'h0, done one-cycle pulse, blk_count=1 (macro on).
- Same block with random sin_valid gaps, then out_ready held low 10 cycles -> identical pt; pt/out_valid stable throughout stall; sin_ready=0 and extra sin_valid bits ignored.
- Three back-to-back blocks with random keys/plaintexts produced by the software TEA encrypt model -> each pt matches the original plaintext; key changed mid-RECV does not affect the result.
- Assert reset after 40 bits, and again during ROUND cycle 15 -> all outputs at reset values; the next full block decrypts correctly with no stale bits.
- ROUNDS=8 build, software model with 8 rounds -> correct pt, latency 8 edges; SUM_INIT=DELTA*8 mod 2^32.
- 65536 blocks with TEA_BLOCK_COUNT_EN defined -> blk_count wraps to 0. Build without the macro -> blk_count constant 0.

Source files
------------

// File: rtl/tea_decrypt_serial_if.sv
// rtl/tea_decrypt_serial_if.sv - serial ciphertext input and plaintext output handshake bundle
interface tea_decrypt_serial_if;
  logic        sin_valid;
  logic        sin_bit;
  logic        sin_ready;
  logic [63:0] pt;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output sin_valid, sin_bit, out_ready,
    input  sin_ready, pt, out_valid
  );

  modport slave (
    input  sin_valid, sin_bit, out_ready,
    output sin_ready, pt, out_valid
  );
endinterface

// File: rtl/tea_decrypt_serial.sv
// rtl/tea_decrypt_serial.sv - bit-serial TEA ciphertext receiver with one-round-per-clock decryption
// Optional completed-block counter enabled by defining TEA_BLOCK_COUNT_EN.
module tea_decrypt_serial #(
  parameter int          ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [127:0]         key,
  tea_decrypt_serial_if.slave  s,
  output logic                 done,
  output logic [15:0]          blk_count
);

  localparam logic [31:0] SUM_INIT = DELTA * 32'(ROUNDS);
  localparam logic [5:0]  LAST_RND = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, RECV, ROUND, OUT} state_t;

  state_t        state_q, state_d;
  logic [63:0]   data_q, data_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [127:0]  key_q, key_d;
  logic [31:0]   sum_q, sum_d;
  logic [5:0]    rnd_q, rnd_d;
  logic          done_q, done_d;

  logic [31:0] v0, v1, v0_n, v1_n;
  logic [31:0] k0, k1, k2, k3;

  assign v0 = data_q[63:32];
  assign v1 = data_q[31:0];
  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // v1 is undone first, and the updated v1 feeds the v0 step within the same cycle.
  always_comb begin
    v1_n = v1 - (((v0 << 4) + k2) ^ (v0 + sum_q) ^ ((v0 >> 5) + k3));
    v0_n = v0 - (((v1_n << 4) + k0) ^ (v1_n + sum_q) ^ ((v1_n >> 5) + k1));
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    sum_d   = sum_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s.sin_valid) begin
          data_d  = {data_q[62:0], s.sin_bit};
          key_d   = key;
          cnt_d   = 7'd1;
          state_d = RECV;
        end
      end
      RECV: begin
        if (s.sin_valid) begin
          data_d = {data_q[62:0], s.sin_bit};
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == 7'd63) begin
            state_d = ROUND;
            sum_d   = SUM_INIT;
            rnd_d   = 6'd0;
          end
        end
      end
      ROUND: begin
        data_d = {v0_n, v1_n};
        sum_d  = sum_q - DELTA;
        rnd_d  = rnd_q + 6'd1;
        if (rnd_q == LAST_RND) begin
          state_d = OUT;
          done_d  = 1'b1;
        end
      end
      OUT: begin
        if (s.out_ready) begin
          state_d = IDLE;
          cnt_d   = 7'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      sum_q   <= SUM_INIT;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      sum_q   <= sum_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign s.sin_ready = (state_q == IDLE) || (state_q == RECV);
  assign s.out_valid = (state_q == OUT);
  assign s.pt        = data_q;
  assign done        = done_q;

`ifdef TEA_BLOCK_COUNT_EN
  logic [15:0] blk_q, blk_d;

  always_comb begin
    blk_d = blk_q;
    if (state_q == OUT && s.out_ready) blk_d = blk_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blk_q <= '0;
    else       blk_q <= blk_d;
  end

  assign blk_count = blk_q;
`else
  assign blk_count = '0;
`endif

endmodule

// File: tb/tb_tea_decrypt_serial.sv
// tb/tb_tea_decrypt_serial.sv - vector table and scoreboard bench for tea_decrypt_serial
module tb_tea_decrypt_serial;
  localparam int          ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;

  typedef struct {
    logic [127:0] key;
    logic [63:0]  pt;
    logic [63:0]  ct;
    bit           gaps;
    bit           keyswap;
    int           stall;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] key = '0;
  logic         done;
  logic [15:0]  blk_count;

  tea_decrypt_serial_if sif();

  tea_decrypt_serial #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .s         (sif.slave),
    .done      (done),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  logic [63:0] sb[$];
  logic        prev_ov = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] p);
    logic [31:0] a, b, s;
    a = p[63:32];
    b = p[31:0];
    s = 32'd0;
    for (int i = 0; i < ROUNDS; i++) begin
      s = s + DELTA;
      a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
    end
    return {a, b};
  endfunction

  // Output monitor: pops the scoreboard on each handshake and checks the done pulse shape.
  always @(negedge clk) begin
    if (reset) begin
      chk1("done_in_reset", done, 1'b0);
    end else begin
      chk1("done_pulse", done, sif.out_valid && !prev_ov);
      if (sif.out_valid && sif.out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: actual=%h required=none", sif.pt);
        end else begin
          chk("pt", sif.pt, sb.pop_front());
        end
        hs_cnt++;
      end
    end
    prev_ov = sif.out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic shift_bits(input logic [127:0] k, input logic [63:0] ct, input int nbits,
                            input bit gaps, input bit keyswap);
    key = k;
    for (int i = 0; i < nbits; i++) begin
      if (gaps && $urandom_range(2) == 0) begin
        sif.sin_valid = 1'b0;
        repeat ($urandom_range(3, 1)) tick();
      end
      chk1("sin_ready_recv", sif.sin_ready, 1'b1);
      sif.sin_valid = 1'b1;
      sif.sin_bit   = ct[63-i];
      tick();
      if (keyswap && i == 20) key = {$urandom, $urandom, $urandom, $urandom};
    end
    sif.sin_valid = 1'b0;
  endtask

  task automatic wait_out();
    int lat;
    lat = 0;
    while (!sif.out_valid && lat < ROUNDS + 20) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(ROUNDS));
    chk1("ov_after_latency", sif.out_valid, 1'b1);
  endtask

  task automatic finish_block(input int stall, input logic [63:0] exp_pt);
    wait_out();
    if (stall > 0) begin
      for (int c = 0; c < stall; c++) begin
        chk1("ov_stall", sif.out_valid, 1'b1);
        chk("pt_stall", sif.pt, exp_pt);
        chk1("sin_ready_out", sif.sin_ready, 1'b0);
        sif.sin_valid = 1'b1;
        sif.sin_bit   = c[0];
        tick();
      end
      sif.out_ready = 1'b1;
    end
    tick();
    sif.sin_valid = 1'b0;
    chk1("ov_after_hs", sif.out_valid, 1'b0);
    chk1("sin_ready_after_hs", sif.sin_ready, 1'b1);
`ifdef TEA_BLOCK_COUNT_EN
    chk("blk_count", 64'(blk_count), 64'(hs_cnt));
`else
    chk("blk_count", 64'(blk_count), 64'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk1("rst_sin_ready", sif.sin_ready, 1'b1);
    chk1("rst_out_valid", sif.out_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_pt", sif.pt, 64'd0);
    chk("rst_blk_count", 64'(blk_count), 64'd0);
    tick();
    reset = 1'b0;
    sb.delete();
    hs_cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t         v[5];
    logic [127:0] k;
    logic [63:0]  p;

    reset         = 1'b1;
    sif.sin_valid = 1'b0;
    sif.sin_bit   = 1'b0;
    sif.out_ready = 1'b1;

    v[0] = '{128'h0, 64'h0, 64'h41EA3A0A94BAA940, 1'b0, 1'b0, 0};
    v[1] = '{128'h0, 64'h0, 64'h41EA3A0A94BAA940, 1'b1, 1'b0, 10};
    for (int i = 2; i < 5; i++) begin
      k    = {$urandom, $urandom, $urandom, $urandom};
      p    = {$urandom, $urandom};
      v[i] = '{k, p, tea_enc(k, p), (i == 4), (i == 3), 0};
    end

    tick();
    tick();
    chk1("init_sin_ready", sif.sin_ready, 1'b1);
    chk1("init_out_valid", sif.out_valid, 1'b0);
    chk1("init_done", done, 1'b0);
    chk("init_pt", sif.pt, 64'd0);
    chk("init_blk_count", 64'(blk_count), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      sif.out_ready = (v[i].stall == 0);
      shift_bits(v[i].key, v[i].ct, 64, v[i].gaps, v[i].keyswap);
      sb.push_back(v[i].pt);
      finish_block(v[i].stall, v[i].pt);
    end
    sif.out_ready = 1'b1;

    shift_bits(v[2].key, v[2].ct, 40, 1'b0, 1'b0);
    do_reset();

    shift_bits(v[3].key, v[3].ct, 64, 1'b0, 1'b0);
    repeat (15) tick();
    chk1("mid_round_out_valid", sif.out_valid, 1'b0);
    chk1("mid_round_sin_ready", sif.sin_ready, 1'b0);
    do_reset();

    shift_bits(v[4].key, v[4].ct, 64, 1'b1, 1'b0);
    sb.push_back(v[4].pt);
    finish_block(0, v[4].pt);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
